// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated N times with an optional gap.
// Optional feature macro: SEQ_GEN_PARITY_EN appends an even-parity bit after every repetition.
module seq_pattern_gen #(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 4,
    parameter  int GAP   = 0,
    localparam int LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             seq_is_parity,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);
    // The gap counter only has to hold GAP-1.
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
`ifdef SEQ_GEN_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]       state_reg,       state_next;
    logic [WIDTH-1:0] pat_reg,         pat_next;
    logic [IDX_W-1:0] last_idx_reg,    last_idx_next;
    logic [IDX_W-1:0] bit_idx_reg,     bit_idx_next;
    logic [CNT_W-1:0] rep_reg,         rep_next;
    logic [GAP_W-1:0] gap_cnt_reg,     gap_cnt_next;
    logic             seq_out_reg,     seq_out_next;
    logic             seq_valid_reg,   seq_valid_next;
    logic             busy_reg,        busy_next;
    logic             done_reg,        done_next;
    logic             start_ready_reg, start_ready_next;

    logic             end_of_rep;
    logic             begin_rep;

    // Out-of-range lengths fall back to the full pattern width.
    logic [LEN_W-1:0] eff_len;
    logic [IDX_W-1:0] first_idx;
    assign eff_len   = (pat_len == '0 || pat_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : pat_len;
    assign first_idx = IDX_W'(eff_len - 1'b1);

`ifdef SEQ_GEN_PARITY_EN
    logic             par_reg, par_next;
    logic             seq_is_parity_reg, seq_is_parity_next;
    logic [WIDTH-1:0] len_mask;

    // Parity covers only the bits that will actually be transmitted.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_len_mask
        assign len_mask[gi] = (LEN_W'(gi) < eff_len);
    end
`endif

    always_comb begin
        state_next       = state_reg;
        pat_next         = pat_reg;
        last_idx_next    = last_idx_reg;
        bit_idx_next     = bit_idx_reg;
        rep_next         = rep_reg;
        gap_cnt_next     = gap_cnt_reg;
        seq_out_next     = seq_out_reg;
        seq_valid_next   = seq_valid_reg;
        busy_next        = busy_reg;
        done_next        = done_reg;
        start_ready_next = start_ready_reg;
        end_of_rep       = 1'b0;
        begin_rep        = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
        par_next           = par_reg;
        seq_is_parity_next = seq_is_parity_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (start_valid && start_ready_reg) begin
                    pat_next         = pattern;
                    last_idx_next    = first_idx;
                    rep_next         = repeat_cnt;
                    busy_next        = 1'b1;
                    start_ready_next = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
                    par_next         = ^(pattern & len_mask);
`endif
                    if (repeat_cnt == '0) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next     = S_SHIFT;
                        bit_idx_next   = first_idx;
                        seq_out_next   = pattern[first_idx];
                        seq_valid_next = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (bit_idx_reg != '0) begin
                    bit_idx_next = bit_idx_reg - 1'b1;
                    seq_out_next = pat_reg[bit_idx_reg - 1'b1];
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    state_next         = S_PARITY;
                    seq_out_next       = par_reg;
                    seq_is_parity_next = 1'b1;
`else
                    end_of_rep = 1'b1;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: begin
                seq_is_parity_next = 1'b0;
                end_of_rep         = 1'b1;
            end
`endif
            S_GAP: begin
                if (gap_cnt_reg != '0) begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end else begin
                    begin_rep = 1'b1;
                end
            end
            S_DONE: begin
                state_next       = S_IDLE;
                done_next        = 1'b0;
                busy_next        = 1'b0;
                start_ready_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (end_of_rep) begin
            if (rep_reg > CNT_W'(1)) begin
                rep_next = rep_reg - 1'b1;
                if (GAP > 0) begin
                    state_next     = S_GAP;
                    gap_cnt_next   = GAP_W'(GAP - 1);
                    seq_valid_next = 1'b0;
                    seq_out_next   = 1'b0;
                end else begin
                    begin_rep = 1'b1;
                end
            end else begin
                rep_next       = '0;
                state_next     = S_DONE;
                done_next      = 1'b1;
                seq_valid_next = 1'b0;
                seq_out_next   = 1'b0;
            end
        end

        // Restart the pattern from its first bit for the next repetition.
        if (begin_rep) begin
            state_next     = S_SHIFT;
            bit_idx_next   = last_idx_reg;
            seq_out_next   = pat_reg[last_idx_reg];
            seq_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            pat_reg         <= '0;
            last_idx_reg    <= '0;
            bit_idx_reg     <= '0;
            rep_reg         <= '0;
            gap_cnt_reg     <= '0;
            seq_out_reg     <= 1'b0;
            seq_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            start_ready_reg <= 1'b1;
        end else begin
            state_reg       <= state_next;
            pat_reg         <= pat_next;
            last_idx_reg    <= last_idx_next;
            bit_idx_reg     <= bit_idx_next;
            rep_reg         <= rep_next;
            gap_cnt_reg     <= gap_cnt_next;
            seq_out_reg     <= seq_out_next;
            seq_valid_reg   <= seq_valid_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            start_ready_reg <= start_ready_next;
        end
    end

`ifdef SEQ_GEN_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_reg           <= 1'b0;
            seq_is_parity_reg <= 1'b0;
        end else begin
            par_reg           <= par_next;
            seq_is_parity_reg <= seq_is_parity_next;
        end
    end

    assign seq_is_parity = seq_is_parity_reg;
`else
    assign seq_is_parity = 1'b0;
`endif

    assign seq_out     = seq_out_reg;
    assign seq_valid   = seq_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign start_ready = start_ready_reg;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (GAP=0 and GAP=2) checked cycle by cycle
// against per-cycle expectation queues built from the transmission rules.
module tb_seq_pattern_gen;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(WIDTH) + 1;
    localparam int GAP_A = 0;
    localparam int GAP_B = 2;

    // Packed observation: {busy, done, seq_valid, seq_out, seq_is_parity, start_ready}
    localparam logic [5:0] IDLE_V = 6'b000001;

    logic             clk = 1'b0;
    logic             rst;
    logic             sv_a, sv_b;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic [CNT_W-1:0] repeat_cnt;

    logic ready_a, out_a, valid_a, par_a, busy_a, done_a;
    logic ready_b, out_b, valid_b, par_b, busy_b, done_b;

    always #5 clk = ~clk;

    seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .start_valid(sv_a), .start_ready(ready_a),
        .pattern(pattern), .pat_len(pat_len), .repeat_cnt(repeat_cnt),
        .seq_out(out_a), .seq_valid(valid_a), .seq_is_parity(par_a),
        .busy(busy_a), .done(done_a)
    );

    seq_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .start_valid(sv_b), .start_ready(ready_b),
        .pattern(pattern), .pat_len(pat_len), .repeat_cnt(repeat_cnt),
        .seq_out(out_b), .seq_valid(valid_b), .seq_is_parity(par_b),
        .busy(busy_b), .done(done_b)
    );

    logic [5:0] obs_a, obs_b;
    assign obs_a = {busy_a, done_a, valid_a, out_a, par_a, ready_a};
    assign obs_b = {busy_b, done_b, valid_b, out_b, par_b, ready_b};

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_a[$];
    logic [5:0] exp_b[$];

    int       det_a, det_b;
    logic [1:0] hist_a, hist_b;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle outputs of one transaction, starting the cycle after acceptance
    // and ending with the first idle cycle.
    task automatic add_stream(input bit to_b, input logic [WIDTH-1:0] p, input int l, input int n);
        int len;
        int gap;
        bit par;
        logic [5:0] e[$];
        len = (l == 0 || l > WIDTH) ? WIDTH : l;
        gap = to_b ? GAP_B : GAP_A;
        for (int r = 0; r < n; r++) begin
            par = 1'b0;
            for (int b = len - 1; b >= 0; b--) begin
                e.push_back({1'b1, 1'b0, 1'b1, p[b], 1'b0, 1'b0});
                par = par ^ p[b];
            end
`ifdef SEQ_GEN_PARITY_EN
            e.push_back({1'b1, 1'b0, 1'b1, par, 1'b1, 1'b0});
`endif
            if (r < n - 1) repeat (gap) e.push_back(6'b100000);
        end
        e.push_back(6'b110000);
        e.push_back(IDLE_V);
        foreach (e[k]) begin
            if (to_b) exp_b.push_back(e[k]);
            else      exp_a.push_back(e[k]);
        end
    endtask

    // Walk both expectation queues; start_valid of each instance drops at its own index.
    task automatic run_checks(input string name, input int drop_a, input int drop_b,
                              input bit swap, input logic [WIDTH-1:0] p2, input int l2, input int n2);
        int n;
        logic [5:0] ea, eb;
        n = (exp_a.size() > exp_b.size()) ? exp_a.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ea = (i < exp_a.size()) ? exp_a[i] : IDLE_V;
            eb = (i < exp_b.size()) ? exp_b[i] : IDLE_V;
            check_val($sformatf("%s_a[%0d]", name, i), {26'd0, obs_a}, {26'd0, ea});
            check_val($sformatf("%s_b[%0d]", name, i), {26'd0, obs_b}, {26'd0, eb});
            if (valid_a && !par_a) begin
                if (hist_a == 2'b11 && !out_a) det_a++;
                hist_a = {hist_a[0], out_a};
            end
            if (valid_b && !par_b) begin
                if (hist_b == 2'b11 && !out_b) det_b++;
                hist_b = {hist_b[0], out_b};
            end
            if (swap && i == 0) begin
                pattern    = p2;
                pat_len    = l2[LEN_W-1:0];
                repeat_cnt = n2[CNT_W-1:0];
            end
            if (i >= drop_a) sv_a = 1'b0;
            if (i >= drop_b) sv_b = 1'b0;
        end
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic single_txn(input string name, input logic [WIDTH-1:0] p, input int l, input int n);
        check_val({name, "_ready_a"}, {31'd0, ready_a}, 32'd1);
        check_val({name, "_ready_b"}, {31'd0, ready_b}, 32'd1);
        pattern    = p;
        pat_len    = l[LEN_W-1:0];
        repeat_cnt = n[CNT_W-1:0];
        sv_a = 1'b1;
        sv_b = 1'b1;
        add_stream(1'b0, p, l, n);
        add_stream(1'b1, p, l, n);
        run_checks(name, 0, 0, 1'b0, '0, 0, 0);
    endtask

    initial begin
        int la, lb;
        logic [WIDTH-1:0] rp;
        rst        = 1'b1;
        sv_a       = 1'b0;
        sv_b       = 1'b0;
        pattern    = '0;
        pat_len    = '0;
        repeat_cnt = '0;
        det_a = 0; det_b = 0; hist_a = 2'b00; hist_b = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        check_val("reset_a", {26'd0, obs_a}, {26'd0, IDLE_V});
        check_val("reset_b", {26'd0, obs_b}, {26'd0, IDLE_V});
        rst = 1'b0;

        // 110 stream, downstream Mealy detector must fire three times
        single_txn("s110", 8'b0000_0110, 3, 3);
        check_val("det110_a", det_a, 32'd3);
        check_val("det110_b", det_b, 32'd3);

        // Length clamp (pat_len=0) with and without gap
        single_txn("clamp", 8'hA5, 0, 2);
        single_txn("zero_rep", 8'hFF, 4, 0);
        single_txn("over_len", 8'h96, 12, 1);

        // Hold start_valid with new values while busy; second request follows the first
        pattern    = 8'b0000_0110;
        pat_len    = 3;
        repeat_cnt = 2;
        sv_a = 1'b1;
        sv_b = 1'b1;
        add_stream(1'b0, 8'b0000_0110, 3, 2);
        add_stream(1'b1, 8'b0000_0110, 3, 2);
        la = exp_a.size();
        lb = exp_b.size();
        add_stream(1'b0, 8'h3C, 6, 1);
        add_stream(1'b1, 8'h3C, 6, 1);
        run_checks("busy", la, lb, 1'b1, 8'h3C, 6, 1);

        // Reset after two bits of a 3x110 transaction
        pattern    = 8'b0000_0110;
        pat_len    = 3;
        repeat_cnt = 3;
        sv_a = 1'b1;
        sv_b = 1'b1;
        @(posedge clk);
        #1;
        sv_a = 1'b0;
        sv_b = 1'b0;
        check_val("rstmid_bit0_a", {26'd0, obs_a}, {26'd0, 6'b101100});
        check_val("rstmid_bit0_b", {26'd0, obs_b}, {26'd0, 6'b101100});
        @(posedge clk);
        #1;
        check_val("rstmid_bit1_a", {26'd0, obs_a}, {26'd0, 6'b101100});
        check_val("rstmid_bit1_b", {26'd0, obs_b}, {26'd0, 6'b101100});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rstmid_idle_a[%0d]", i), {26'd0, obs_a}, {26'd0, IDLE_V});
            check_val($sformatf("rstmid_idle_b[%0d]", i), {26'd0, obs_b}, {26'd0, IDLE_V});
            @(posedge clk);
            #1;
        end
        single_txn("after_rst", 8'b0000_0110, 3, 3);

        // Parity-relevant patterns (plain streams when parity is not built in)
        single_txn("par110", 8'b0000_0110, 3, 2);
        single_txn("par111", 8'b0000_0111, 3, 1);

        for (int t = 0; t < 40; t++) begin
            rp = WIDTH'($urandom);
            single_txn($sformatf("rnd%0d", t), rp, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter. Accepts a parallel pattern word, a length and a repeat count over a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, repeated N times, with an optional idle gap between repetitions.
- Generating end of the serial bit-stream protocol: drives the seq_in input of the sequence-detector blocks (e.g. the 110 detector) in system-level and self-checking benches.

Parameters:
- WIDTH, 8, maximum pattern length in bits (must be >= 2).
- CNT_W, 4, width of the repeat-count field.
- GAP, 0, idle cycles inserted between consecutive repetitions (none after the last).
- Localparam LEN_W = $clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  request to transmit
- start_ready  out  1  block can accept a request this cycle
- pattern  in  WIDTH  pattern bits; bit [pat_len-1] is sent first
- pat_len  in  LEN_W  bits per repetition, 1..WIDTH
- repeat_cnt  in  CNT_W  number of repetitions
- seq_out  out  1  serial data bit
- seq_valid  out  1  seq_out carries a valid bit
- seq_is_parity  out  1  current bit is a parity bit (see Optional Feature)
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction

Behaviour:
- One clock domain. Reset is synchronous and active-high, with clock port clk and reset port rst.
- Reset values: seq_out=0, seq_valid=0, seq_is_parity=0, busy=0, done=0, start_ready=1. State is IDLE.
- FSM states: IDLE, SHIFT, GAP, DONE. All outputs are registered.
- IDLE:
  - start_ready=1.
  - On a clock edge where start_valid && start_ready, latch pattern, pat_len and repeat_cnt.
  - Input changes after acceptance are ignored.
- Length clamp: pat_len==0 or pat_len>WIDTH is treated as WIDTH.
- repeat_cnt==0: go IDLE->DONE. No bits are emitted. done pulses in the cycle after acceptance.
- Otherwise go to SHIFT:
  - The first bit appears on seq_out, with seq_valid=1, in the cycle after acceptance.
  - Each bit is held exactly one cycle. Bit order is pattern[len-1] down to pattern[0].
- End of a repetition:
  - If more repetitions remain and GAP>0: enter GAP for exactly GAP cycles with seq_valid=0 and seq_out=0, then resume SHIFT at bit len-1.
  - If more repetitions remain and GAP==0: the next repetition follows back-to-back.
- After the final bit: go to DONE for 1 cycle.
  - done=1, seq_valid=0, seq_out=0, start_ready=0.
  - Then go to IDLE.
- Latency: total cycles from acceptance to done = repeat_cnt*len + (repeat_cnt-1)*GAP + 1 (plus parity bits when enabled).
- busy=1 in SHIFT, GAP and DONE. start_ready = ~busy.
- start_valid while busy: ignored, not queued.
- Reset mid-transaction: at the reset edge all outputs return to reset values and the transaction is discarded. No done pulse is produced.
- Counters: the bit index and the repetition counter decrement and saturate at 0. There is no wrap-around.

Optional Feature:
- Macro: SEQ_GEN_PARITY_EN.
- Defined:
  - After the last data bit of every repetition, one extra bit is emitted with seq_valid=1 and seq_is_parity=1.
  - Its value is the even parity: XOR of the len transmitted bits.
  - The GAP, if any, follows the parity bit.
  - Each repetition becomes len+1 cycles long.
- Undefined: no parity bit is emitted, and seq_is_parity is tied to 0.

Test Plan:
- Basic 110 stream:
  - Stimulus: pattern=8'b0000_0110, pat_len=3, repeat_cnt=3, GAP=0.
  - Required: seq_out = 1,1,0,1,1,0,1,1,0 on 9 consecutive seq_valid cycles starting 1 cycle after acceptance.
  - Required: done pulses on cycle 10 after acceptance.
  - Required: a downstream 110 Mealy detector asserts exactly 3 times.
- Gap and clamp:
  - Stimulus: GAP=2, pattern=8'hA5, pat_len=0, repeat_cnt=2.
  - Required: 10100101, then 2 cycles with seq_valid=0, then 10100101.
  - Required: done on cycle 19 after acceptance.
- Zero repeats:
  - Stimulus: repeat_cnt=0.
  - Required: no seq_valid. busy=1 and done=1 on cycle 1, start_ready=1 on cycle 2.
- Busy / handshake:
  - Stimulus: hold start_valid=1 with new pattern values during a transaction.
  - Required: the second request is accepted only on the cycle start_ready returns to 1.
  - Required: the first stream is uncorrupted.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle after 2 bits of a 3x110 transaction.
  - Required: next cycle seq_valid=0, busy=0, start_ready=1, no done pulse.
  - Required: a new request afterwards starts cleanly.
- Parity (SEQ_GEN_PARITY_EN):
  - Stimulus: pattern 110, len 3, repeat 2.
  - Required: 1,1,0,P=0,1,1,0,P=0, with seq_is_parity=1 only on P.
  - Stimulus: pattern 111. Required: P=1.
